// File: rtl/ir.sv
// Instruction register: captures ir_in on ld, holds it for the decoder.
// Also exposes opcode/operand slices and a sticky valid flag.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-low reset
//   ld       load enable, sampled on rising clk
//   ir_in    instruction byte from the memory data bus
//   ir_out   registered instruction
//   opcode   upper OPC_W bits of ir_out
//   operand  lower WIDTH-OPC_W bits of ir_out
//   ir_valid set by the first load after reset
module ir #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned OPC_W = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ld,
  input  logic [WIDTH-1:0]       ir_in,
  output logic [WIDTH-1:0]       ir_out,
  output logic [OPC_W-1:0]       opcode,
  output logic [WIDTH-OPC_W-1:0] operand,
  output logic                   ir_valid
);

  generate
    if (OPC_W < 1 || OPC_W >= WIDTH) begin : g_bad_opc_w
      $error("ir: OPC_W must be in 1..WIDTH-1");
    end
  endgenerate

  logic [WIDTH-1:0] r_ir;
  logic             r_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ir    <= RST_VAL;
      r_valid <= 1'b0;
    end else if (ld) begin
      r_ir    <= ir_in;
      r_valid <= 1'b1;
    end
  end

  assign ir_out   = r_ir;
  assign ir_valid = r_valid;
  assign opcode   = r_ir[WIDTH-1 -: OPC_W];
  assign operand  = r_ir[WIDTH-OPC_W-1:0];

endmodule

// File: tb/tb_ir.sv
// Bench for ir: directed stimulus pushes expected values into a queue,
// a monitor process pops and compares shortly after each push.
module tb_ir;

  typedef struct {
    logic [7:0] out;
    logic [3:0] opc;
    logic [3:0] opr;
    logic       v;
    string      nm;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       ld;
  logic [7:0] ir_in;
  logic [7:0] ir_out;
  logic [3:0] opcode;
  logic [3:0] operand;
  logic       ir_valid;

  int checks   = 0;
  int failures = 0;
  exp_t q[$];

  ir #(
    .WIDTH(8),
    .OPC_W(4),
    .RST_VAL(8'h00)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ld(ld),
    .ir_in(ir_in),
    .ir_out(ir_out),
    .opcode(opcode),
    .operand(operand),
    .ir_valid(ir_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_v(input logic [7:0] o,
                          input logic [3:0] opc,
                          input logic [3:0] opr,
                          input logic v,
                          input string nm);
    exp_t e;
    e.out = o;
    e.opc = opc;
    e.opr = opr;
    e.v   = v;
    e.nm  = nm;
    q.push_back(e);
  endtask

  // drive at negedge, let one rising edge pass, settle 2 time units
  task automatic step(input logic l, input logic [7:0] d);
    @(negedge clk);
    ld    = l;
    ir_in = d;
    @(posedge clk);
    #2;
  endtask

  task automatic chk8(input string nm, input logic [7:0] a,
                      input logic [7:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      wait (q.size() != 0);
      #1;
      e = q.pop_front();
      chk8({e.nm, ".ir_out"}, ir_out, e.out);
      chk8({e.nm, ".opcode"}, {4'h0, opcode}, {4'h0, e.opc});
      chk8({e.nm, ".operand"}, {4'h0, operand}, {4'h0, e.opr});
      chk8({e.nm, ".valid"}, {7'h0, ir_valid}, {7'h0, e.v});
    end
  end

  initial begin
    reset = 1'b0;
    ld    = 1'b1;
    ir_in = 8'hFF;
    #1;
    expect_v(8'h00, 4'h0, 4'h0, 1'b0, "rst_async");
    @(posedge clk);
    @(posedge clk);
    #2;
    expect_v(8'h00, 4'h0, 4'h0, 1'b0, "rst_held");

    // release and load 6D
    @(negedge clk);
    reset = 1'b1;
    ir_in = 8'h6D;
    @(posedge clk);
    #2;
    expect_v(8'h6D, 4'h6, 4'hD, 1'b1, "load_6d");

    // hold
    step(1'b0, 8'hA5);
    expect_v(8'h6D, 4'h6, 4'hD, 1'b1, "hold_a5");
    step(1'b0, 8'h95);
    expect_v(8'h6D, 4'h6, 4'hD, 1'b1, "hold_95");
    step(1'b0, 8'h00);
    expect_v(8'h6D, 4'h6, 4'hD, 1'b1, "hold_00");

    // back-to-back loads
    step(1'b1, 8'hA5);
    expect_v(8'hA5, 4'hA, 4'h5, 1'b1, "ld_a5");
    step(1'b1, 8'h95);
    expect_v(8'h95, 4'h9, 4'h5, 1'b1, "ld_95");

    // mid-cycle change: not transparent, only edge value captured
    @(negedge clk);
    ir_in = 8'h11;
    #1;
    expect_v(8'h95, 4'h9, 4'h5, 1'b1, "no_transp");
    #2;
    ir_in = 8'h53;
    @(posedge clk);
    #2;
    expect_v(8'h53, 4'h5, 4'h3, 1'b1, "ld_53");

    // async reset pulse between edges, ld=1
    @(negedge clk);
    ir_in = 8'hC7;
    #1;
    reset = 1'b0;
    expect_v(8'h00, 4'h0, 4'h0, 1'b0, "rst_pulse");
    #2;
    reset = 1'b1;
    @(posedge clk);
    #2;
    expect_v(8'hC7, 4'hC, 4'h7, 1'b1, "reload_c7");

    // reset held across an edge with ld=1: reset wins
    @(negedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #2;
    expect_v(8'h00, 4'h0, 4'h0, 1'b0, "rst_vs_ld");

    // load value equal to RST_VAL still sets valid
    @(negedge clk);
    reset = 1'b1;
    ir_in = 8'h00;
    @(posedge clk);
    #2;
    expect_v(8'h00, 4'h0, 4'h0, 1'b1, "ld_zero");
    step(1'b0, 8'hEE);
    expect_v(8'h00, 4'h0, 4'h0, 1'b1, "hold_valid");

    // drain scoreboard with a bound
    repeat (20) begin
      if (q.size() != 0) @(posedge clk);
    end
    #5;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
